// File: rtl/board_read_arbiter_if.sv
// Board read-port bundle: requester requests/addresses on one side, arbitrated
// board address, read data and status on the other.
interface board_read_arbiter_if #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3,
  parameter int DATA_W   = 2
);
  logic [2:0]          req;
  logic                lock0;
  logic [ROW_BITS-1:0] row0;
  logic [ROW_BITS-1:0] row1;
  logic [ROW_BITS-1:0] row2;
  logic [COL_BITS-1:0] col0;
  logic [COL_BITS-1:0] col1;
  logic [COL_BITS-1:0] col2;
  logic [2:0]          gnt;
  logic [ROW_BITS-1:0] mem_r_row;
  logic [COL_BITS-1:0] mem_r_col;
  logic [DATA_W-1:0]   mem_data_in;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic [1:0]          rid;
  logic                lock_active;
  logic                starve_evt;

  modport master (
    output req, lock0, row0, row1, row2, col0, col1, col2, mem_data_in,
    input  gnt, mem_r_row, mem_r_col, rdata, rvalid, rid, lock_active, starve_evt
  );

  modport slave (
    input  req, lock0, row0, row1, row2, col0, col1, col2, mem_data_in,
    output gnt, mem_r_row, mem_r_col, rdata, rvalid, rid, lock_active, starve_evt
  );
endinterface

// File: rtl/board_read_arbiter.sv
// Three-way arbiter for the board read port: lockable requester 0, round-robin
// 1/2 with starvation promotion, registered read data tagged with owner id.
module board_read_arbiter #(
  parameter int ROW_BITS  = 3,
  parameter int COL_BITS  = 3,
  parameter int DATA_W    = 2,
  parameter int MAX_WAIT  = 15,
  parameter int WAIT_BITS = 4
) (
  input logic               clk,
  input logic               rst_n,
  board_read_arbiter_if.slave bus
);

  // state     | meaning
  // ST_OPEN   | normal arbitration (starvation, req0, round-robin 1/2)
  // ST_LOCKED | requester 0 owns the port; 1 and 2 blocked
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [WAIT_BITS-1:0] LP_MAX_WAIT = WAIT_BITS'(MAX_WAIT);
  localparam logic [WAIT_BITS-1:0] LP_ONE      = WAIT_BITS'(1);

  state_t              r_state;
  logic [WAIT_BITS-1:0] r_wait1;
  logic [WAIT_BITS-1:0] r_wait2;
  logic                r_rr;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic [1:0]          r_rid;
  logic                r_starve_evt;

  logic [2:0]          w_gnt;
  logic                w_starve;
  logic [1:0]          w_gid;
  logic                w_starving1;
  logic                w_starving2;

  assign w_starving1 = bus.req[1] && (r_wait1 == LP_MAX_WAIT);
  assign w_starving2 = bus.req[2] && (r_wait2 == LP_MAX_WAIT);

  always_comb begin
    w_gnt    = 3'b000;
    w_starve = 1'b0;
    if (!rst_n) begin
      w_gnt = 3'b000;
    end else if (r_state == ST_LOCKED) begin
      w_gnt[0] = bus.req[0];
    end else if (w_starving1) begin
      w_gnt    = 3'b010;
      w_starve = 1'b1;
    end else if (w_starving2) begin
      w_gnt    = 3'b100;
      w_starve = 1'b1;
    end else if (bus.req[0]) begin
      w_gnt = 3'b001;
    end else if (!r_rr) begin
      if (bus.req[1])      w_gnt = 3'b010;
      else if (bus.req[2]) w_gnt = 3'b100;
    end else begin
      if (bus.req[2])      w_gnt = 3'b100;
      else if (bus.req[1]) w_gnt = 3'b010;
    end
  end

  always_comb begin
    w_gid = 2'd0;
    if (w_gnt[2])      w_gid = 2'd2;
    else if (w_gnt[1]) w_gid = 2'd1;
  end

  // Idle address follows requester 1 so the display scan keeps reading.
  always_comb begin
    bus.mem_r_row = bus.row1;
    bus.mem_r_col = bus.col1;
    if (w_gnt[0]) begin
      bus.mem_r_row = bus.row0;
      bus.mem_r_col = bus.col0;
    end else if (w_gnt[2]) begin
      bus.mem_r_row = bus.row2;
      bus.mem_r_col = bus.col2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_OPEN;
      r_wait1      <= '0;
      r_wait2      <= '0;
      r_rr         <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_rid        <= 2'd0;
      r_starve_evt <= 1'b0;
    end else begin
      case (r_state)
        ST_OPEN:   if (w_gnt[0] && bus.lock0) r_state <= ST_LOCKED;
        ST_LOCKED: if (!bus.lock0 || !bus.req[0]) r_state <= ST_OPEN;
        default:   r_state <= ST_OPEN;
      endcase

      // Counters keep saturating while locked, so promotion fires on unlock.
      if (w_gnt[1] || !bus.req[1])   r_wait1 <= '0;
      else if (r_wait1 != LP_MAX_WAIT) r_wait1 <= r_wait1 + LP_ONE;

      if (w_gnt[2] || !bus.req[2])   r_wait2 <= '0;
      else if (r_wait2 != LP_MAX_WAIT) r_wait2 <= r_wait2 + LP_ONE;

      if (w_gnt[1])      r_rr <= 1'b1;
      else if (w_gnt[2]) r_rr <= 1'b0;

      r_rvalid     <= |w_gnt;
      r_starve_evt <= w_starve;
      if (|w_gnt) begin
        r_rdata <= bus.mem_data_in;
        r_rid   <= w_gid;
      end
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.rdata       = r_rdata;
  assign bus.rvalid      = r_rvalid;
  assign bus.rid         = r_rid;
  assign bus.lock_active = (r_state == ST_LOCKED);
  assign bus.starve_evt  = r_starve_evt;

endmodule
